// File: rtl/seg7_capture_pkg.sv
// ============================================================================
// Module      : seg7_capture_pkg
// Description : Shared FSM encoding, 7-segment glyph table and csn helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [6:0] c_blank = 7'h00;

    // Segment order {a,b,c,d,e,f,g}; entry n is the glyph for hex digit n
    localparam logic [6:0] c_glyph [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic onehot_low(input logic [7:0] csn);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (!csn[i]) n++;
        end
        return (n == 1);
    endfunction

    function automatic logic [2:0] low_index(input logic [7:0] csn);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!csn[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : Combinational 7-segment pattern to hex nibble classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import seg7_capture_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_is_glyph,
    output logic       o_is_blank,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_is_glyph = 1'b0;
        o_nibble   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == c_glyph[i]) begin
                o_is_glyph = 1'b1;
                o_nibble   = 4'(i);
            end
        end
    end

    assign o_is_blank = (i_seg == c_blank);

endmodule

`default_nettype wire

// File: rtl/seg7_capture.sv
// ============================================================================
// Module      : seg7_capture
// Description : Debounces a multiplexed 8-digit 7-segment bus into hex digits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_capture
    import seg7_capture_pkg::*;
#(
    parameter int SETTLE_CYC = 4
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  num_csn,
    input  logic [6:0]  num_a_g,
    output logic [31:0] value,
    output logic [7:0]  digit_valid,
    output logic        upd,
    output logic        bad_seg
);

    localparam logic [7:0] c_settle = 8'(SETTLE_CYC);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        w_latch;

    logic [7:0]  r_csn;
    logic [6:0]  r_seg;
    logic [7:0]  r_prev_csn;
    logic [6:0]  r_prev_seg;

    logic [31:0] r_value;
    logic [7:0]  r_valid;
    logic        r_pend;
    logic        r_upd;
    logic        r_bad;

    logic        w_sel;
    logic        w_same;
    logic [4:0]  w_lsb;
    logic        w_is_glyph;
    logic        w_is_blank;
    logic [3:0]  w_nibble;
    logic [31:0] w_value_nxt;
    logic [7:0]  w_valid_nxt;
    logic        w_bad;
    logic        w_changed;

    assign w_sel  = onehot_low(r_csn);
    assign w_same = (r_csn == r_prev_csn) && (r_seg == r_prev_seg);
    assign w_lsb  = {low_index(r_csn), 2'b00};

    seg7_decode u_decode (
        .i_seg      (r_seg),
        .o_is_glyph (w_is_glyph),
        .o_is_blank (w_is_blank),
        .o_nibble   (w_nibble)
    );

    // The latch fires on the edge where the count would reach SETTLE_CYC
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = 8'd1;
                end
            end
            ST_SETTLE: begin
                if (!w_sel) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (!w_same) begin
                    w_cnt_nxt   = 8'd1;
                end else if (r_cnt >= c_settle - 8'd1) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_settle;
                    w_latch     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (!w_sel) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (!w_same) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_comb begin
        w_value_nxt = r_value;
        w_valid_nxt = r_valid;
        w_bad       = 1'b0;
        if (w_latch) begin
            if (w_is_glyph) begin
                w_value_nxt[w_lsb +: 4]      = w_nibble;
                w_valid_nxt[w_lsb[4:2]]      = 1'b1;
            end else if (w_is_blank) begin
                w_value_nxt[w_lsb +: 4]      = 4'd0;
                w_valid_nxt[w_lsb[4:2]]      = 1'b0;
            end else begin
                w_bad = 1'b1;
            end
        end
    end

    assign w_changed = w_latch && ({w_value_nxt, w_valid_nxt} != {r_value, r_valid});

    // upd is delayed a second stage so it lands the cycle after new data is visible
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_csn      <= 8'hFF;
            r_seg      <= 7'h00;
            r_prev_csn <= 8'hFF;
            r_prev_seg <= 7'h00;
            r_value    <= 32'd0;
            r_valid    <= 8'd0;
            r_pend     <= 1'b0;
            r_upd      <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_csn      <= num_csn;
            r_seg      <= num_a_g;
            r_prev_csn <= r_csn;
            r_prev_seg <= r_seg;
            r_value    <= w_value_nxt;
            r_valid    <= w_valid_nxt;
            r_pend     <= w_changed;
            r_upd      <= r_pend;
            r_bad      <= w_bad;
        end
    end

    assign value       = r_value;
    assign digit_valid = r_valid;
    assign upd         = r_upd;
    assign bad_seg     = r_bad;

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture.sv
// ============================================================================
// Module      : tb_seg7_capture
// Description : Scoreboard bench for seg7_capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_capture;

    localparam int SETTLE_CYC = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  num_csn = 8'hFF;
    logic [6:0]  num_a_g = 7'h00;
    logic [31:0] value;
    logic [7:0]  digit_valid;
    logic        upd;
    logic        bad_seg;

    always #5 clk = ~clk;

    seg7_capture #(.SETTLE_CYC(SETTLE_CYC)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .num_csn     (num_csn),
        .num_a_g     (num_a_g),
        .value       (value),
        .digit_valid (digit_valid),
        .upd         (upd),
        .bad_seg     (bad_seg)
    );

    typedef struct {
        bit          is_bad;
        logic [31:0] val;
        logic [7:0]  vld;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          upd_cnt = 0;
    int          bad_cnt = 0;
    int          last_upd_cyc = 0;
    int          t_start = 0;
    logic [31:0] m_val = 32'd0;
    logic [7:0]  m_vld = 8'd0;
    logic [7:0]  last_csn = 8'hFF;
    logic [6:0]  last_seg = 7'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // 0..15 glyph, 16 blank, -1 anything else
    function automatic int glyph_of(input logic [6:0] s);
        if (s == 7'h00) return 16;
        for (int i = 0; i < 16; i++) begin
            if (s == GLYPH[i]) return i;
        end
        return -1;
    endfunction

    // Hold one pattern for n cycles; predicts any resulting pulse
    task automatic drive(input logic [7:0] csn, input logic [6:0] seg, input int n);
        exp_t        e;
        int          g;
        int          idx;
        int          zeros;
        logic [31:0] nv;
        logic [7:0]  nl;
        @(posedge clk);
        #1;
        num_csn = csn;
        num_a_g = seg;
        t_start = cyc;
        zeros = 0;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (!csn[i]) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros == 1 && n >= SETTLE_CYC && !(csn == last_csn && seg == last_seg)) begin
            g  = glyph_of(seg);
            nv = m_val;
            nl = m_vld;
            if (g >= 0 && g < 16) begin
                nv[idx*4 +: 4] = 4'(g);
                nl[idx] = 1'b1;
            end else if (g == 16) begin
                nv[idx*4 +: 4] = 4'd0;
                nl[idx] = 1'b0;
            end
            if (g < 0) begin
                e.is_bad = 1'b1; e.val = m_val; e.vld = m_vld;
                sb.push_back(e);
            end else if ({nv, nl} != {m_val, m_vld}) begin
                e.is_bad = 1'b0; e.val = nv; e.vld = nl;
                sb.push_back(e);
            end
            m_val = nv;
            m_vld = nl;
        end
        last_csn = csn;
        last_seg = seg;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (upd === 1'b1 || bad_seg === 1'b1) begin
                if (upd === 1'b1) begin
                    upd_cnt++;
                    last_upd_cyc = cyc;
                end
                if (bad_seg === 1'b1) bad_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {30'd0, upd, bad_seg}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", {30'd0, upd, bad_seg}, e.is_bad ? 32'd1 : 32'd2);
                    check("sb_value", value, e.val);
                    check("sb_valid", {24'd0, digit_valid}, {24'd0, e.vld});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat0;
        int u0;
        int b0;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", value, 32'd0);
        check("rst_valid", {24'd0, digit_valid}, 32'd0);
        check("rst_upd", {31'd0, upd}, 32'd0);
        check("rst_bad", {31'd0, bad_seg}, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Single digit, long hold: exactly one update with fixed latency
        drive(8'hFE, 7'h30, 10);
        lat0 = t_start;
        drive(8'hFF, 7'h00, 8);
        check("d0_value", value, 32'h00000001);
        check("d0_valid", {24'd0, digit_valid}, 32'h01);
        check("d0_upd_cnt", upd_cnt, 1);
        check("d0_bad_cnt", bad_cnt, 0);
        check("d0_latency", last_upd_cyc - lat0, SETTLE_CYC + 2);

        // Scan all eight digits
        for (int i = 0; i < 8; i++) begin
            drive(8'(~(8'h01 << i)), GLYPH[i+1], 6);
        end
        drive(8'hFF, 7'h00, 8);
        check("scan_value", value, 32'h87654321);
        check("scan_valid", {24'd0, digit_valid}, 32'hFF);
        check("scan_upd_cnt", upd_cnt, 8);

        // Short transient 8 followed by a stable 1
        drive(8'hFB, 7'h7F, 2);
        drive(8'hFB, 7'h30, 8);
        drive(8'hFF, 7'h00, 8);
        check("glitch_nib2", {28'd0, value[11:8]}, 32'd1);
        check("glitch_value", value, 32'h87654121);

        // Illegal pattern
        u0 = upd_cnt;
        b0 = bad_cnt;
        drive(8'hFD, 7'h2A, 6);
        drive(8'hFF, 7'h00, 8);
        check("bad_pulses", bad_cnt - b0, 1);
        check("bad_no_upd", upd_cnt - u0, 0);
        check("bad_value", value, 32'h87654121);
        check("bad_valid", {24'd0, digit_valid}, 32'hFF);

        // Exactly SETTLE_CYC latches, one fewer does not
        drive(8'hFE, 7'h79, SETTLE_CYC);
        drive(8'hFE, 7'h33, SETTLE_CYC - 1);
        drive(8'hFF, 7'h00, 8);
        check("edge_value", value, 32'h87654123);

        // Not selected: multi-low and none-low
        u0 = upd_cnt;
        b0 = bad_cnt;
        drive(8'hF5, 7'h30, 20);
        drive(8'hFF, 7'h30, 20);
        check("nosel_upd", upd_cnt - u0, 0);
        check("nosel_bad", bad_cnt - b0, 0);
        check("nosel_value", value, 32'h87654123);

        // Digit 5 then blank clears it
        u0 = upd_cnt;
        drive(8'hFE, 7'h5B, 6);
        drive(8'hFE, 7'h00, 6);
        drive(8'hFF, 7'h00, 8);
        check("blank_nib0", {28'd0, value[3:0]}, 32'd0);
        check("blank_valid0", {31'd0, digit_valid[0]}, 32'd0);
        check("blank_upd_cnt", upd_cnt - u0, 2);

        // Reset one edge before the latch would occur
        u0 = upd_cnt;
        b0 = bad_cnt;
        drive(8'hFB, 7'h4E, 3);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1;
        num_csn = 8'hFF;
        num_a_g = 7'h00;
        @(negedge clk);
        check("mid_rst_value", value, 32'd0);
        check("mid_rst_valid", {24'd0, digit_valid}, 32'd0);
        check("mid_rst_upd", {31'd0, upd}, 32'd0);
        check("mid_rst_bad", {31'd0, bad_seg}, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        m_val = 32'd0;
        m_vld = 8'd0;
        last_csn = 8'hFF;
        last_seg = 7'h00;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("post_rst_upd", upd_cnt - u0, 0);
        check("post_rst_bad", bad_cnt - b0, 0);
        check("post_rst_value", value, 32'd0);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
